// File: rtl/psram_responder.sv
// SPI/QPI PSRAM target emulator: oversamples the psram bus in sys_clk, decodes 02h/03h and serves a byte array.
// Quad commands 38h/EBh are enabled by defining PSRAM_RESPONDER_QPI_EN; otherwise they are rejected.
`timescale 1ns/1ps
module psram_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_reset_n,
    input  logic       psram_ce_n,
    input  logic       psram_clk,
    input  logic [3:0] psram_sio_in,
    output logic [3:0] psram_sio_out,
    output logic [3:0] psram_sio_oe,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       cmd_err
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_WR, S_RD, S_IGNORE
    } state_t;

    state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0]      r_ce_sync, r_clk_sync;
    logic [SYNC_STAGES-1:0][3:0] r_sio_sync;
    logic                        r_clk_prev, r_ce_prev;

    logic [4:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_rd_shift;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_quad, r_read;
    logic [7:0]           r_mem [DEPTH];

    logic                 w_ce_s, w_clk_s, w_rise, w_fall, w_select;
    logic [3:0]           w_sio;
    logic [7:0]           w_serial_byte, w_wr_byte, w_pf_data;
    logic [ADDR_BITS-1:0] w_addr_in, w_addr_inc, w_pf_addr;
    logic                 w_cmd_ok, w_cmd_quad, w_cmd_read;
    logic                 w_unit_last, w_addr_last, w_mem_we;

    // ce_n idles high, so its synchronizer resets high to avoid a false select.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_ce_sync  <= '1;
            r_clk_sync <= '0;
            r_sio_sync <= '0;
            r_clk_prev <= 1'b0;
            r_ce_prev  <= 1'b1;
        end else begin
            r_ce_sync  <= {r_ce_sync[SYNC_STAGES-2:0], psram_ce_n};
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], psram_clk};
            r_sio_sync <= {r_sio_sync[SYNC_STAGES-2:0], psram_sio_in};
            r_clk_prev <= w_clk_s;
            r_ce_prev  <= w_ce_s;
        end
    end

    assign w_ce_s   = r_ce_sync[SYNC_STAGES-1];
    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_sio    = r_sio_sync[SYNC_STAGES-1];
    assign w_rise   = w_clk_s & ~r_clk_prev;
    assign w_fall   = ~w_clk_s & r_clk_prev;
    assign w_select = r_ce_prev & ~w_ce_s;

    assign w_serial_byte = {r_shift[6:0], w_sio[0]};
    assign w_wr_byte     = r_quad ? {r_shift[3:0], w_sio} : w_serial_byte;
    assign w_addr_in     = r_quad ? {r_addr[ADDR_BITS-5:0], w_sio}
                                  : {r_addr[ADDR_BITS-2:0], w_sio[0]};
    assign w_addr_inc    = r_addr + 1'b1;
    assign w_unit_last   = r_quad ? (r_bit_cnt == 5'd1) : (r_bit_cnt == 5'd7);
    assign w_addr_last   = r_quad ? (r_bit_cnt == 5'd5) : (r_bit_cnt == 5'd23);

    // Read prefetch: the first byte at the end of the address, then the following byte after each one sent.
    assign w_pf_addr = (r_state == S_ADDR) ? w_addr_in : w_addr_inc;
    assign w_pf_data = r_mem[w_pf_addr];

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_cmd_ok   = 1'b0;
        w_cmd_quad = 1'b0;
        w_cmd_read = 1'b0;
        case (w_serial_byte)
            8'h02: w_cmd_ok = 1'b1;
            8'h03: begin
                w_cmd_ok   = 1'b1;
                w_cmd_read = 1'b1;
            end
`ifdef PSRAM_RESPONDER_QPI_EN
            8'h38: begin
                w_cmd_ok   = 1'b1;
                w_cmd_quad = 1'b1;
            end
            8'hEB: begin
                w_cmd_ok   = 1'b1;
                w_cmd_quad = 1'b1;
                w_cmd_read = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (w_ce_s) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_select) w_state_next = S_CMD;
                S_CMD:  if (w_rise && r_bit_cnt == 5'd7)
                            w_state_next = w_cmd_ok ? S_ADDR : S_IGNORE;
                S_ADDR: if (w_rise && w_addr_last)
                            w_state_next = !r_read ? S_WR : (r_quad ? S_WAIT : S_RD);
                S_WAIT: if (w_rise && r_bit_cnt == 5'd5) w_state_next = S_RD;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    assign w_mem_we = !w_ce_s && (r_state == S_WR) && w_rise && w_unit_last;

    // NOTE: the byte array has no reset; contents survive sys_reset_n, which also lets it map onto RAM.
    always_ff @(posedge sys_clk) begin
        if (w_mem_we) r_mem[r_addr] <= w_wr_byte;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            psram_sio_out <= 4'h0;
            psram_sio_oe  <= 4'h0;
            cmd_valid     <= 1'b0;
            cmd_code      <= 8'h00;
            cmd_err       <= 1'b0;
            r_bit_cnt     <= 5'd0;
            r_shift       <= 8'h00;
            r_rd_shift    <= 8'h00;
            r_addr        <= '0;
            r_quad        <= 1'b0;
            r_read        <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (w_ce_s) begin
                psram_sio_oe <= 4'h0;
                r_bit_cnt    <= 5'd0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_select) begin
                        r_bit_cnt <= 5'd0;
                        r_quad    <= 1'b0;
                        r_read    <= 1'b0;
                    end
                    S_CMD: if (w_rise) begin
                        r_shift   <= w_serial_byte;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= w_serial_byte;
                            cmd_err   <= !w_cmd_ok;
                            r_quad    <= w_cmd_quad;
                            r_read    <= w_cmd_read;
                            r_bit_cnt <= 5'd0;
                        end
                    end
                    S_ADDR: if (w_rise) begin
                        r_addr    <= w_addr_in;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (w_addr_last) begin
                            r_bit_cnt  <= 5'd0;
                            r_rd_shift <= w_pf_data;
                        end
                    end
                    S_WAIT: if (w_rise) begin
                        r_bit_cnt <= (r_bit_cnt == 5'd5) ? 5'd0 : r_bit_cnt + 5'd1;
                    end
                    S_WR: if (w_rise) begin
                        r_shift   <= w_wr_byte;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (w_unit_last) begin
                            r_bit_cnt <= 5'd0;
                            r_addr    <= w_addr_inc;
                        end
                    end
                    S_RD: if (w_fall) begin
                        if (r_quad) begin
                            psram_sio_out <= r_rd_shift[7:4];
                            psram_sio_oe  <= 4'hF;
                            r_rd_shift    <= {r_rd_shift[3:0], 4'h0};
                        end else begin
                            psram_sio_out <= {2'b00, r_rd_shift[7], 1'b0};
                            psram_sio_oe  <= 4'b0010;
                            r_rd_shift    <= {r_rd_shift[6:0], 1'b0};
                        end
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (w_unit_last) begin
                            r_bit_cnt  <= 5'd0;
                            r_addr     <= w_addr_inc;
                            r_rd_shift <= w_pf_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_responder.sv
// Scoreboard bench for psram_responder: stimulus pushes expected commands/read bytes, monitors pop and compare.
// Honors PSRAM_RESPONDER_QPI_EN the same way the design does.
`timescale 1ns/1ps
module tb_psram_responder;
    localparam int HALF = 6;   // sys_clk periods per psram_clk phase
    localparam int MEM  = 1024;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n = 1'b0;
    logic       psram_ce_n = 1'b1;
    logic       psram_clk = 1'b0;
    logic [3:0] psram_sio_in = 4'h0;
    logic [3:0] psram_sio_out, psram_sio_oe;
    logic       cmd_valid, cmd_err;
    logic [7:0] cmd_code;

    always #5 sys_clk = ~sys_clk;

    psram_responder #(.ADDR_BITS(10), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .psram_ce_n(psram_ce_n), .psram_clk(psram_clk),
        .psram_sio_in(psram_sio_in), .psram_sio_out(psram_sio_out),
        .psram_sio_oe(psram_sio_oe), .cmd_valid(cmd_valid),
        .cmd_code(cmd_code), .cmd_err(cmd_err)
    );

    typedef struct packed { logic quad; logic [7:0] data; } rd_exp_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] cmd_q[$];      // {err, code}
    rd_exp_t    rd_q[$];
    logic [7:0] model [MEM];
    int         asm_cnt = 0;
    logic [7:0] asm_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // Command monitor: every cycle with cmd_valid/cmd_err high must match one queued command.
    initial forever begin
        @(negedge sys_clk);
        if (sys_reset_n && (cmd_valid || cmd_err)) begin
            if (cmd_q.size() == 0) begin
                unexpected("cmd_pulse", {22'd0, cmd_valid, cmd_err, cmd_code});
            end else begin
                logic [8:0] e;
                e = cmd_q.pop_front();
                check("cmd_valid", cmd_valid, 1);
                check("cmd_code", cmd_code, e[7:0]);
                check("cmd_err", cmd_err, e[8]);
            end
        end
    end

    // Read monitor: assemble bytes from driven lanes at each controller sampling edge.
    initial forever begin
        @(posedge psram_clk);
        if (psram_sio_oe == 4'b0010) begin
            asm_byte = {asm_byte[6:0], psram_sio_out[1]};
            asm_cnt += 1;
        end else if (psram_sio_oe == 4'hF) begin
            asm_byte = {asm_byte[3:0], psram_sio_out};
            asm_cnt += 4;
        end else if (psram_sio_oe != 4'h0) begin
            unexpected("sio_oe_value", psram_sio_oe);
        end
        if (asm_cnt >= 8) begin
            asm_cnt = 0;
            if (rd_q.size() == 0) begin
                unexpected("read_byte", asm_byte);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("read_data", asm_byte, e.data);
                check("read_oe", psram_sio_oe, e.quad ? 4'hF : 4'h2);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic bus_clk(input logic [3:0] d);
        psram_clk = 1'b0;
        psram_sio_in = d;
        tick(HALF);
        psram_clk = 1'b1;
        tick(HALF);
    endtask

    task automatic select_dev();
        psram_clk = 1'b0;
        psram_ce_n = 1'b0;
        asm_cnt = 0;
        tick(HALF);
    endtask

    task automatic deselect_dev();
        tick(2);
        psram_ce_n = 1'b1;
        tick(2);
        psram_clk = 1'b0;
        tick(3 * HALF);
    endtask

    function automatic logic supported(input logic [7:0] c);
`ifdef PSRAM_RESPONDER_QPI_EN
        return c == 8'h02 || c == 8'h03 || c == 8'h38 || c == 8'hEB;
`else
        return c == 8'h02 || c == 8'h03;
`endif
    endfunction

    task automatic send_cmd(input logic [7:0] c);
        cmd_q.push_back({!supported(c), c});
        for (int i = 7; i >= 0; i--) begin
            logic [3:0] r;
            r = 4'($urandom);
            r[0] = c[i];
            bus_clk(r);
        end
    endtask

    task automatic send_addr(input logic [23:0] a, input logic quad);
        if (quad) for (int i = 5; i >= 0; i--) bus_clk(a[i*4 +: 4]);
        else for (int i = 23; i >= 0; i--) bus_clk({3'b000, a[i]});
    endtask

    task automatic send_byte(input logic [7:0] b, input logic quad);
        if (quad) begin
            bus_clk(b[7:4]);
            bus_clk(b[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) bus_clk({3'b000, b[i]});
        end
    endtask

    // Bytes are taken from data[31:24] first; the model commits whole bytes at wrapped addresses.
    task automatic do_write(input logic [23:0] a, input logic quad, input int len, input logic [31:0] data);
        select_dev();
        send_cmd(quad ? 8'h38 : 8'h02);
        send_addr(a, quad);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = data[31 - 8*k -: 8];
            send_byte(b, quad);
            model[(int'(a) + k) % MEM] = b;
        end
        deselect_dev();
    endtask

    task automatic do_read(input logic [23:0] a, input logic quad, input int len);
        select_dev();
        send_cmd(quad ? 8'hEB : 8'h03);
        send_addr(a, quad);
        if (quad) repeat (6) bus_clk(4'($urandom));
        for (int k = 0; k < len; k++) begin
            rd_q.push_back({quad, model[(int'(a) + k) % MEM]});
            repeat (quad ? 2 : 8) bus_clk(4'($urandom));
        end
        deselect_dev();
    endtask

    task automatic do_bogus(input logic [7:0] c, input int clocks);
        select_dev();
        send_cmd(c);
        repeat (clocks) bus_clk(4'($urandom));
        check("ignore_oe", psram_sio_oe, 4'h0);
        deselect_dev();
    endtask

    initial begin
        tick(3);
        check("rst_sio_out", psram_sio_out, 4'h0);
        check("rst_sio_oe", psram_sio_oe, 4'h0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_code", cmd_code, 8'h00);
        check("rst_cmd_err", cmd_err, 1'b0);
        sys_reset_n = 1'b1;
        tick(4);

        // Basic write then read of two bytes.
        do_write(24'h000010, 1'b0, 2, 32'hA53C_0000);
        do_read(24'h000010, 1'b0, 2);

        // Asynchronous reset in the middle of a read byte.
        select_dev();
        send_cmd(8'h03);
        send_addr(24'h000010, 1'b0);
        repeat (4) bus_clk(4'h0);
        tick(2);
        check("pre_reset_oe", psram_sio_oe, 4'b0010);
        check("pre_reset_code", cmd_code, 8'h03);
        #2;
        sys_reset_n = 1'b0;
        #1;
        check("mid_rst_sio_oe", psram_sio_oe, 4'h0);
        check("mid_rst_sio_out", psram_sio_out, 4'h0);
        check("mid_rst_cmd_code", cmd_code, 8'h00);
        check("mid_rst_cmd_err", cmd_err, 1'b0);
        psram_ce_n = 1'b1;
        psram_clk = 1'b0;
        tick(4);
        sys_reset_n = 1'b1;
        tick(4);

        // Address wrap at the top of the 1 KiB array, upper address bits ignored.
        do_write(24'h0003FF, 1'b0, 2, 32'h1122_0000);
        do_read(24'h000000, 1'b0, 1);
        do_read(24'h0003FF, 1'b0, 2);
        do_read(24'hABC7FF, 1'b0, 2);

        // Partial byte at deselect is discarded.
        do_write(24'h000020, 1'b0, 1, 32'h7700_0000);
        select_dev();
        send_cmd(8'h02);
        send_addr(24'h000020, 1'b0);
        repeat (4) bus_clk(4'h0);
        deselect_dev();
        do_read(24'h000020, 1'b0, 1);

        // Unsupported command parks in IGNORE until deselect.
        do_bogus(8'h9F, 40);

`ifdef PSRAM_RESPONDER_QPI_EN
        do_write(24'h000040, 1'b1, 1, 32'h5A00_0000);
        do_read(24'h000040, 1'b1, 1);
`else
        do_bogus(8'h38, 8);
        do_bogus(8'hEB, 8);
`endif

        // Randomized bursts, read back through an aliased address.
        for (int t = 0; t < 12; t++) begin
            logic [23:0] a, a2;
            logic        qw, qr;
            int          len;
            a   = 24'($urandom);
            a2  = (24'($urandom) & 24'hFFFC00) | (a & 24'h0003FF);
            len = $urandom_range(1, 4);
`ifdef PSRAM_RESPONDER_QPI_EN
            qw = 1'($urandom);
            qr = 1'($urandom);
`else
            qw = 1'b0;
            qr = 1'b0;
`endif
            do_write(a, qw, len, $urandom);
            do_read(a2, qr, len);
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] bad [4];
                bad = '{8'h9F, 8'h05, 8'h35, 8'h66};
                do_bogus(bad[$urandom_range(0, 3)], 10);
            end
        end

        tick(20);
        check("cmd_q_drained", cmd_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
